instr_fetch: RTL and testbench

Instruction fetch stage of the xiao-rv core: owns the program counter, issues word-aligned read requests to instruction memory, and buffers the returned words. It presents each instruction with its PC to the decoder over a valid/ready handshake. Redirects from execute (branches, jumps) flush buffered and in-flight fetches, so the decoder never sees a wrong-path instruction.

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_pkg : shared fetch-stage types and constants           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  localparam int unsigned c_instr_w    = 32;
  localparam int unsigned c_word_align = 2;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo : synchronous FIFO with flush, count and full/empty     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam int unsigned c_cnt_w = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] rd_ptr_q;
  logic [c_ptr_w-1:0] wr_ptr_q;
  logic [c_cnt_w-1:0] count_q;
  logic               do_push;
  logic               do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == c_cnt_w'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is cleared on reset so the head reads as zero before any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + c_ptr_w'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
      end
      count_q <= count_q + c_cnt_w'(do_push) - c_cnt_w'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch : PC owner, imem requester and decoder-facing buffer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = c_instr_w,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter int unsigned   BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc
);

  localparam int unsigned   c_cnt_w   = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned   c_entry_w = DW + AW;
  localparam logic [AW-1:0] c_pc_step = AW'(1) << c_word_align;

  fetch_state_e        state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [c_cnt_w-1:0]  outstanding_q, outstanding_d;
  logic [c_cnt_w-1:0]  stale_q, stale_d;
  logic [c_cnt_w:0]    stale_sum;
  logic [c_cnt_w:0]    credit_used;
  logic                req_hs;
  logic                pop_credit;
  logic [AW-1:0]       rsp_pc;
  logic                fifo_push;
  logic                fifo_pop;
  logic [c_entry_w-1:0] fifo_rdata;
  logic [c_cnt_w-1:0]  fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[c_word_align-1:0];

  // The head entry leaving this cycle frees its slot, which is what lets a
  // latency-1 memory sustain one instruction per cycle with two entries.
  assign pop_credit  = !fifo_empty && instr_ready;
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count}
                     - (c_cnt_w + 1)'(pop_credit);

  assign imem_req_valid = (state_q == FETCH_RUN)
                       && (credit_used < (c_cnt_w + 1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // Requests in flight are consecutive words ending just below pc_q.
  assign rsp_pc = pc_q - (AW'(outstanding_q) << c_word_align);

  assign fifo_push   = imem_rsp_valid && (state_q == FETCH_RUN) && !redirect_valid;
  assign instr_valid = !fifo_empty && !redirect_valid;
  assign fifo_pop    = instr_valid && instr_ready;
  assign instr       = fifo_rdata[c_entry_w-1:AW];
  assign instr_pc    = fifo_rdata[AW-1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    stale_sum     = {1'b0, stale_q} + {1'b0, outstanding_q}
                  + (c_cnt_w + 1)'(req_hs) - (c_cnt_w + 1)'(imem_rsp_valid);
    if (redirect_valid) begin
      pc_d          = {redirect_pc[AW-1:c_word_align], {c_word_align{1'b0}}};
      outstanding_d = '0;
      stale_d       = stale_sum[c_cnt_w-1:0];
      state_d       = (stale_sum != '0) ? FETCH_DRAIN : FETCH_RUN;
    end else begin
      unique case (state_q)
        FETCH_BOOT: state_d = FETCH_RUN;
        FETCH_RUN: begin
          if (req_hs) begin
            pc_d = pc_q + c_pc_step;
          end
          outstanding_d = outstanding_q + c_cnt_w'(req_hs) - c_cnt_w'(imem_rsp_valid);
        end
        FETCH_DRAIN: begin
          if (imem_rsp_valid) begin
            stale_d = stale_q - c_cnt_w'(1);
            if (stale_q == c_cnt_w'(1)) begin
              state_d = FETCH_RUN;
            end
          end
        end
        default: state_d = FETCH_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (c_entry_w)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .wdata_i ({imem_rsp_data, rsp_pc}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_credit_holds: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> (!fifo_full || fifo_pop));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_fetch : scoreboard bench for instr_fetch                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // Second instance only exercises the address wrap from the top word.
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_one  = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'h0;

  instr_fetch #(.AW(32), .DW(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  instr_fetch #(.AW(32), .DW(32), .RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(w_zero), .redirect_pc(w_zero32),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_one),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_zero), .imem_rsp_data(w_zero32),
    .instr_valid(w_instr_valid), .instr_ready(w_zero),
    .instr(w_instr), .instr_pc(w_instr_pc)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  mreq_t       mq[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          lat_min, lat_max;
  int          first_instr_cyc;
  int          n_consumed;
  int          n_reqs;
  logic [31:0] exp_addr;
  logic [31:0] exp_wrap_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input bit mem_rdy, input bit dec_rdy, input bit redir, input logic [31:0] rpc);
    bit   stale_pending;
    exp_t e;
    @(negedge clk);
    stale_pending = 1'b0;
    foreach (mq[i]) if (mq[i].stale) stale_pending = 1'b1;
    imem_req_ready = mem_rdy;
    instr_ready    = dec_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    if (stale_pending) check_eq("drain_no_req", imem_req_valid, 0);
    if (redir) check_eq("redirect_blocks_valid", instr_valid, 0);
    if (instr_valid && instr_ready) begin
      n_consumed++;
      if (first_instr_cyc < 0) first_instr_cyc = cyc;
      check_eq("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("instr_pc", instr_pc, e.pc);
        check_eq("instr", instr, e.data);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      check_eq("req_addr", imem_req_addr, exp_addr);
      mq.push_back('{addr: imem_req_addr,
                     due: cyc + int'($urandom_range(lat_max, lat_min)),
                     stale: 1'b0});
      sb.push_back('{pc: exp_addr, data: mem_word(exp_addr)});
      exp_addr += 32'd4;
      n_reqs++;
    end
    if (redir) begin
      sb.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      exp_addr = {rpc[31:2], 2'b00};
    end
    if (w_req_valid) begin
      check_eq("wrap_req_addr", w_req_addr, exp_wrap_addr);
      exp_wrap_addr += 32'd4;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    #1;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    mq.delete();
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_req_addr", imem_req_addr, 32'h0);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_instr_pc", instr_pc, 0);
    check_eq("rst_wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
    rst_n           = 1'b1;
    cyc             = 0;
    exp_addr        = 32'h0;
    exp_wrap_addr   = 32'hFFFF_FFFC;
    first_instr_cyc = -1;
    n_consumed      = 0;
    n_reqs          = 0;
  endtask

  task automatic end_test();
    for (int i = 0; i < 40 && (sb.size() != 0 || mq.size() != 0); i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
    end
    check_eq("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;

    // Latency-1 memory, decoder always ready.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    c0 = n_consumed;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("first_instr_cycle", first_instr_cyc, 3);
    check_eq("throughput", n_consumed - c0, 10);
    end_test();

    // Decoder stalled for 10 cycles.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("stall_reqs_le2", n_reqs <= 2, 1);
    check_eq("stall_valid", instr_valid, 1);
    check_eq("stall_pc", instr_pc, 32'h0);
    end_test();

    // Redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("inflight_reqs", n_reqs, 2);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    end_test();

    // Redirect coinciding with a request handshake and a response.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("post_redirect_reqs", n_reqs > 2, 1);
    end_test();

    // Random latency, backpressure and redirects.
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
            $urandom_range(24, 0) == 0, $urandom & 32'h0000_3FFF);
    end
    end_test();
    check_eq("random_progress", n_consumed > 500, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
